// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the RV32I core, with load-use hazard detection,
// flush/stall handling and a saturating bubble counter.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1data,
    input  logic [XLEN-1:0]  id_rs2data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_memtoreg,
    input  logic             id_memwrite,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             id_aluinputpc,
    input  logic             id_branchjalx,
    input  logic             id_alu2pc,
    input  logic [1:0]       id_aluop,
    input  logic             stall,
    input  logic             flush,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1data,
    output logic [XLEN-1:0]  ex_rs2data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic             ex_aluinputpc,
    output logic             ex_branchjalx,
    output logic             ex_alu2pc,
    output logic [1:0]       ex_aluop,
    output logic             ex_valid,
    output logic             clearcontrol,
    output logic             hold_ifid,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_REG    = 5'b01100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [10:0] ctrl_p0;
    logic [10:0] ctrl_p1;
    logic [4:0]  opc;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        loaduse;
    logic        bubble;
    logic        advance;
    logic        squash;
    logic        unused_opcode_lsbs;

    assign unused_opcode_lsbs = &{1'b0, id_opcode[1:0]};

    assign ctrl_p0 = {id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc,
                      id_regwrite, id_aluinputpc, id_branchjalx, id_alu2pc, id_aluop};

    assign opc      = id_opcode[6:2];
    assign uses_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    assign uses_rs2 = (opc == OPC_REG) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

    // A load whose result is needed in ID forces one bubble; x0 never creates a dependency.
    assign loaduse = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                     ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2))) &
                     ~flush;

    assign bubble       = loaduse & ~stall;
    assign clearcontrol = bubble;
    assign hold_ifid    = bubble;

    // Flush overrides stall; any advancing edge with flush or a bubble zeroes the stage.
    assign advance = flush | ~stall;
    assign squash  = flush | loaduse;

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_p1     <= '0;
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1data  <= '0;
            ex_rs2data  <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            bubble_cnt  <= '0;
        end else if (advance) begin
            ctrl_p1     <= (squash || !id_valid) ? '0 : ctrl_p0;
            ex_valid    <= ~squash & id_valid;
            ex_pc       <= squash ? '0 : id_pc;
            ex_rs1data  <= squash ? '0 : id_rs1data;
            ex_rs2data  <= squash ? '0 : id_rs2data;
            ex_imm      <= squash ? '0 : id_imm;
            ex_rs1      <= squash ? '0 : id_rs1;
            ex_rs2      <= squash ? '0 : id_rs2;
            ex_rd       <= squash ? '0 : id_rd;
            ex_funct3   <= squash ? '0 : id_funct3;
            ex_funct7b5 <= ~squash & id_funct7b5;
            if (bubble) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end

    assign {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
            ex_regwrite, ex_aluinputpc, ex_branchjalx, ex_alu2pc, ex_aluop} = ctrl_p1;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed vectors push hand-computed expectations,
// a monitor pops them and compares against the EX-side outputs.
module tb_id_ex_reg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    // {branch, memread, memtoreg, memwrite, alusrc, regwrite, aluinputpc, branchjalx, alu2pc, aluop}
    localparam logic [10:0] C_ADDI = 11'b00001100011;
    localparam logic [10:0] C_LW   = 11'b01101100000;
    localparam logic [10:0] C_ADD  = 11'b00000100010;
    localparam logic [10:0] C_LUI  = 11'b00001100000;
    localparam logic [10:0] C_JAL  = 11'b00000101100;

    typedef struct {
        logic        cc;
        logic        ev;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [10:0] ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [6:0]  id_opcode = '0;
    logic [31:0] id_pc = '0, id_rs1data = '0, id_rs2data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [2:0]  id_funct3 = '0;
    logic        id_funct7b5 = 1'b0;
    logic [10:0] id_ctl = '0;
    logic        stall = 1'b0, flush = 1'b0;

    logic [31:0] ex_pc, ex_rs1data, ex_rs2data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc;
    logic        ex_regwrite, ex_aluinputpc, ex_branchjalx, ex_alu2pc, ex_valid;
    logic [1:0]  ex_aluop;
    logic        clearcontrol, hold_ifid;
    logic [15:0] bubble_cnt;
    logic [10:0] ex_ctl;

    logic [31:0] s_pc, s_rs1data, s_rs2data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_funct3;
    logic        s_funct7b5, s_branch, s_memread, s_memtoreg, s_memwrite, s_alusrc;
    logic        s_regwrite, s_aluinputpc, s_branchjalx, s_alu2pc, s_valid, s_cc, s_hold;
    logic [1:0]  s_aluop;
    logic [2:0]  s_cnt;

    assign ex_ctl = {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
                     ex_regwrite, ex_aluinputpc, ex_branchjalx, ex_alu2pc, ex_aluop};

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
        .id_rs1data(id_rs1data), .id_rs2data(id_rs2data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_branch(id_ctl[10]), .id_memread(id_ctl[9]),
        .id_memtoreg(id_ctl[8]), .id_memwrite(id_ctl[7]), .id_alusrc(id_ctl[6]),
        .id_regwrite(id_ctl[5]), .id_aluinputpc(id_ctl[4]), .id_branchjalx(id_ctl[3]),
        .id_alu2pc(id_ctl[2]), .id_aluop(id_ctl[1:0]), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_aluinputpc(ex_aluinputpc), .ex_branchjalx(ex_branchjalx),
        .ex_alu2pc(ex_alu2pc), .ex_aluop(ex_aluop), .ex_valid(ex_valid),
        .clearcontrol(clearcontrol), .hold_ifid(hold_ifid), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy on the same stimulus to reach saturation in few cycles.
    id_ex_reg #(.XLEN(32), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
        .id_rs1data(id_rs1data), .id_rs2data(id_rs2data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_branch(id_ctl[10]), .id_memread(id_ctl[9]),
        .id_memtoreg(id_ctl[8]), .id_memwrite(id_ctl[7]), .id_alusrc(id_ctl[6]),
        .id_regwrite(id_ctl[5]), .id_aluinputpc(id_ctl[4]), .id_branchjalx(id_ctl[3]),
        .id_alu2pc(id_ctl[2]), .id_aluop(id_ctl[1:0]), .stall(stall), .flush(flush),
        .ex_pc(s_pc), .ex_rs1data(s_rs1data), .ex_rs2data(s_rs2data), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3),
        .ex_funct7b5(s_funct7b5), .ex_branch(s_branch), .ex_memread(s_memread),
        .ex_memtoreg(s_memtoreg), .ex_memwrite(s_memwrite), .ex_alusrc(s_alusrc),
        .ex_regwrite(s_regwrite), .ex_aluinputpc(s_aluinputpc), .ex_branchjalx(s_branchjalx),
        .ex_alu2pc(s_alu2pc), .ex_aluop(s_aluop), .ex_valid(s_valid),
        .clearcontrol(s_cc), .hold_ifid(s_hold), .bubble_cnt(s_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [6:0] op, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] d1, input logic [10:0] ctl,
                         input logic st, input logic fl);
        @(posedge clk);
        #2;
        id_valid = v; id_opcode = op; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_imm = imm; id_rs1data = d1; id_rs2data = ~d1; id_funct3 = rd[2:0];
        id_funct7b5 = rs1[0]; id_ctl = ctl; stall = st; flush = fl;
    endtask

    task automatic push(input logic cc, input logic ev, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] d1, input logic [10:0] ctl, input logic [15:0] cnt);
        exp_t e;
        e.cc = cc; e.ev = ev; e.rd = rd; e.rs1 = rs1; e.pc = pc; e.imm = imm;
        e.d1 = d1; e.ctl = ctl; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic push_zero(input logic cc, input logic [15:0] cnt);
        push(cc, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 11'h0, cnt);
    endtask

    // Monitor: hazard outputs mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("clearcontrol", {31'h0, clearcontrol}, {31'h0, e.cc});
                chk("hold_ifid", {31'h0, hold_ifid}, {31'h0, e.cc});
                @(posedge clk);
                #1;
                chk("ex_valid", {31'h0, ex_valid}, {31'h0, e.ev});
                chk("ex_ctl", {21'h0, ex_ctl}, {21'h0, e.ctl});
                chk("ex_rd", {27'h0, ex_rd}, {27'h0, e.rd});
                chk("ex_rs1", {27'h0, ex_rs1}, {27'h0, e.rs1});
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_imm", ex_imm, e.imm);
                chk("ex_rs1data", ex_rs1data, e.d1);
                chk("ex_funct3", {29'h0, ex_funct3}, {29'h0, e.rd[2:0]});
                chk("bubble_cnt", {16'h0, bubble_cnt}, {16'h0, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        repeat (2) @(posedge clk);
        #3;
        chk("reset ex_valid", {31'h0, ex_valid}, 32'h0);
        chk("reset ex_ctl", {21'h0, ex_ctl}, 32'h0);
        chk("reset bubble_cnt", {16'h0, bubble_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // addi x5,x0,7
        issue(1, OP_ADDI, 32'h00, 0, 0, 5, 32'd7, 32'h11, C_ADDI, 0, 0);
        push(0, 1, 5, 0, 32'h00, 32'd7, 32'h11, C_ADDI, 0);
        // lw x6,0(x1) ; add x7,x6,x2 -> one bubble, then add captured
        issue(1, OP_LW, 32'h04, 1, 0, 6, 32'd0, 32'h22, C_LW, 0, 0);
        push(0, 1, 6, 1, 32'h04, 32'd0, 32'h22, C_LW, 0);
        issue(1, OP_ADD, 32'h08, 6, 2, 7, 32'd0, 32'h33, C_ADD, 0, 0);
        push_zero(1, 1);
        issue(1, OP_ADD, 32'h08, 6, 2, 7, 32'd0, 32'h33, C_ADD, 0, 0);
        push(0, 1, 7, 6, 32'h08, 32'd0, 32'h33, C_ADD, 1);
        // lw x0 ; add x8,x0,x0 -> no hazard
        issue(1, OP_LW, 32'h0C, 1, 0, 0, 32'd0, 32'h44, C_LW, 0, 0);
        push(0, 1, 0, 1, 32'h0C, 32'd0, 32'h44, C_LW, 1);
        issue(1, OP_ADD, 32'h10, 0, 0, 8, 32'd0, 32'h55, C_ADD, 0, 0);
        push(0, 1, 8, 0, 32'h10, 32'd0, 32'h55, C_ADD, 1);
        // lw x6 ; lui x6 -> no hazard
        issue(1, OP_LW, 32'h14, 1, 0, 6, 32'd4, 32'h66, C_LW, 0, 0);
        push(0, 1, 6, 1, 32'h14, 32'd4, 32'h66, C_LW, 1);
        issue(1, OP_LUI, 32'h18, 6, 0, 6, 32'h12345000, 32'h77, C_LUI, 0, 0);
        push(0, 1, 6, 6, 32'h18, 32'h12345000, 32'h77, C_LUI, 1);
        // lw x6 ; jal x6 -> no hazard
        issue(1, OP_LW, 32'h1C, 1, 0, 6, 32'd8, 32'h88, C_LW, 0, 0);
        push(0, 1, 6, 1, 32'h1C, 32'd8, 32'h88, C_LW, 1);
        issue(1, OP_JAL, 32'h20, 6, 6, 6, 32'h100, 32'h99, C_JAL, 0, 0);
        push(0, 1, 6, 6, 32'h20, 32'h100, 32'h99, C_JAL, 1);
        // flush together with a load-use pair
        issue(1, OP_LW, 32'h24, 1, 0, 6, 32'd0, 32'hAA, C_LW, 0, 0);
        push(0, 1, 6, 1, 32'h24, 32'd0, 32'hAA, C_LW, 1);
        issue(1, OP_ADD, 32'h28, 6, 2, 7, 32'd0, 32'hAB, C_ADD, 0, 1);
        push_zero(0, 1);
        // stall for 3 cycles holds ex_pc at 0x40
        issue(1, OP_ADDI, 32'h40, 0, 0, 9, 32'd1, 32'hBB, C_ADDI, 0, 0);
        push(0, 1, 9, 0, 32'h40, 32'd1, 32'hBB, C_ADDI, 1);
        for (int i = 0; i < 3; i++) begin
            issue(1, OP_ADDI, 32'h44, 0, 0, 10, 32'd2, 32'hCC, C_ADDI, 1, 0);
            push(0, 1, 9, 0, 32'h40, 32'd1, 32'hBB, C_ADDI, 1);
        end
        // stall together with load-use: hold, then the bubble once stall drops
        issue(1, OP_LW, 32'h44, 1, 0, 6, 32'd0, 32'hCC, C_LW, 0, 0);
        push(0, 1, 6, 1, 32'h44, 32'd0, 32'hCC, C_LW, 1);
        issue(1, OP_ADD, 32'h48, 6, 2, 7, 32'd0, 32'hDD, C_ADD, 1, 0);
        push(0, 1, 6, 1, 32'h44, 32'd0, 32'hCC, C_LW, 1);
        issue(1, OP_ADD, 32'h48, 6, 2, 7, 32'd0, 32'hDD, C_ADD, 0, 0);
        push_zero(1, 2);
        issue(1, OP_ADD, 32'h48, 6, 2, 7, 32'd0, 32'hDD, C_ADD, 0, 0);
        push(0, 1, 7, 6, 32'h48, 32'd0, 32'hDD, C_ADD, 2);
        // id_valid=0: controls captured as zero, data still passes
        issue(0, OP_ADD, 32'h4C, 3, 0, 4, 32'd0, 32'hEE, C_ADD, 0, 0);
        push(0, 0, 4, 3, 32'h4C, 32'd0, 32'hEE, 11'h0, 2);
        // nine more load-use bubbles; the 3-bit copy pins at 7
        for (int i = 0; i < 9; i++) begin
            issue(1, OP_LW, 32'h50 + 32'(8 * i), 1, 0, 6, 32'd0, 32'(i), C_LW, 0, 0);
            push(0, 1, 6, 1, 32'h50 + 32'(8 * i), 32'd0, 32'(i), C_LW, 16'(2 + i));
            issue(1, OP_ADD, 32'h54 + 32'(8 * i), 6, 2, 7, 32'd0, 32'h100 + 32'(i), C_ADD, 0, 0);
            push_zero(1, 16'(3 + i));
        end
        issue(1, OP_ADDI, 32'h80, 0, 0, 5, 32'd7, 32'h1, C_ADDI, 0, 0);
        push(0, 1, 5, 0, 32'h80, 32'd7, 32'h1, C_ADDI, 11);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        chk("small bubble_cnt saturated", {29'h0, s_cnt}, 32'd7);

        // Asynchronous reset in the middle of a cycle with a live instruction in EX
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset ex_valid", {31'h0, ex_valid}, 32'h0);
        chk("midreset ex_regwrite", {31'h0, ex_regwrite}, 32'h0);
        chk("midreset ex_ctl", {21'h0, ex_ctl}, 32'h0);
        chk("midreset ex_pc", ex_pc, 32'h0);
        chk("midreset ex_imm", ex_imm, 32'h0);
        chk("midreset ex_rd", {27'h0, ex_rd}, 32'h0);
        chk("midreset bubble_cnt", {16'h0, bubble_cnt}, 32'h0);
        chk("midreset small bubble_cnt", {29'h0, s_cnt}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
